tcdm_burst_streamer: RTL and testbench
======================================

TCDM_BURST_STREAMER -- requirements
Module: tcdm_burst_streamer

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32: TCDM address width in bits.
REQ-002 SHALL have parameter DATA_WIDTH, default 32: TCDM read-data width in bits.
REQ-003 SHALL have parameter LEN_WIDTH, default 16: width of the burst-length field.
REQ-004 SHALL have parameter MAX_OUTST, default 4, range 1..16: credit limit, equal to in-flight requests plus buffered words.
REQ-005 SHALL have one clock and a synchronous active-high reset; clk_i and rst_i, defined below.
REQ-006 clk_i  input  1  clock; all state updates on its rising edge.
REQ-007 rst_i  input  1  synchronous reset, active high.
REQ-008 start_i  input  1  launch a burst; sampled in IDLE only.
REQ-009 base_addr_i  input  ADDR_WIDTH  first word address; captured at launch.
REQ-010 stride_i  input  ADDR_WIDTH  address increment per word; captured at launch.
REQ-011 len_i  input  LEN_WIDTH  number of words in the burst; captured at launch.
REQ-012 busy_o  output  1  high whenever the FSM is not in IDLE.
REQ-013 done_o  output  1  one-cycle pulse at burst completion.
REQ-014 tcdm_req_o  output  1  TCDM request.
REQ-015 tcdm_addr_o  output  ADDR_WIDTH  TCDM address.
REQ-016 tcdm_gnt_i  input  1  TCDM grant.
REQ-017 tcdm_r_valid_i  input  1  TCDM response valid; cannot be back-pressured.
REQ-018 tcdm_r_rdata_i  input  DATA_WIDTH  TCDM response data.
REQ-019 data_valid_o  output  1  buffered word available.
REQ-020 data_o  output  DATA_WIDTH  head word of the buffer.
REQ-021 data_ready_i  input  1  consumer accepts data_o.

Function
REQ-022 FSM SHALL have exactly three states: IDLE, STREAM and DRAIN.
REQ-023 IDLE with start_i=1 and len_i!=0: SHALL capture base, stride and len, clear issued/outstanding counters, and go to STREAM next cycle.
REQ-024 IDLE with start_i=1 and len_i=0: SHALL issue no request, pulse done_o the next cycle and remain in IDLE.
REQ-025 start_i SHALL be ignored outside IDLE.
REQ-026 Credit count SHALL be outstanding (granted, no response yet) plus buffer occupancy.
REQ-027 In STREAM, tcdm_req_o SHALL be 1 iff issued < len and credits < MAX_OUTST.
REQ-028 Once asserted, tcdm_req_o and tcdm_addr_o SHALL remain stable until tcdm_gnt_i is sampled high.
REQ-029 tcdm_addr_o SHALL equal base + issued*stride, computed by a registered accumulator, modulo 2^ADDR_WIDTH (wrap, no error).
REQ-030 A request SHALL be accepted in a cycle where tcdm_req_o and tcdm_gnt_i are both 1; it increments issued and outstanding, and back-to-back grants SHALL sustain 1 word/cycle.
REQ-031 tcdm_r_valid_i=1 SHALL push tcdm_r_rdata_i into a MAX_OUTST-deep FIFO and decrement outstanding; no overflow is possible by construction.
REQ-032 When tcdm_r_valid_i is 1 and outstanding is 0, the design SHALL ignore the response and the SVA assertion SHALL flag it.
REQ-033 FIFO SHALL be first-word-fall-through: data_valid_o = FIFO not empty, data_o = head entry, pop on data_valid_o & data_ready_i.
REQ-034 Simultaneous push and pop SHALL leave occupancy unchanged, including when the FIFO is full or empty; push to an empty FIFO is visible on data_o the next cycle.
REQ-035 Grant, response and pop in the same cycle SHALL update all counters consistently; credits change by +1 (grant), -1 (pop) or 0 (both).
REQ-036 STREAM SHALL go to DRAIN in the cycle after the last grant (issued == len).
REQ-037 DRAIN SHALL go to IDLE when outstanding == 0 and the FIFO is empty, with done_o pulsed in that same transition cycle.
REQ-038 Response order SHALL equal request order; data_o order SHALL equal address order.

Reset
REQ-039 rst_i=1 SHALL, at the next edge regardless of state, force IDLE, zero all counters, empty the FIFO, and drive tcdm_req_o=0, tcdm_addr_o=0, data_valid_o=0, data_o=0, busy_o=0, done_o=0.
REQ-040 Responses arriving after a mid-burst reset SHALL be discarded under the REQ-032 rule.

Verification
REQ-041 base=0x1000, stride=4, len=8, gnt always 1, r_valid 1 cycle after gnt, ready=1 -> addresses 0x1000..0x101C on 8 consecutive cycles, 8 words in order, one done_o pulse.
REQ-042 MAX_OUTST=4, len=10, ready=0 -> exactly 4 grants, then tcdm_req_o=0 with 4 words buffered; ready=1 -> remaining 6 issued, 10 words delivered.
REQ-043 len=0 -> no tcdm_req_o, done_o high one cycle after start, busy_o stays 0.
REQ-044 base=0xFFFFFFF8, stride=4, len=4 -> addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x0, 0x4.
REQ-045 Random gnt/r_valid latency 0..5 cycles, random ready -> addr/req stable until gnt, no FIFO overflow, data order preserved.
REQ-046 rst_i asserted with 2 requests outstanding -> IDLE next cycle, all outputs 0; late r_valid ignored; new burst completes correctly.

Source files
------------

// File: rtl/tcdm_burst_streamer_if.sv
// TCDM request/response channel plus the streamed-data consumer handshake.
// The master side is the streamer; the slave side is the memory and consumer.
interface tcdm_burst_streamer_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  tcdm_req_o;
    logic [ADDR_WIDTH-1:0] tcdm_addr_o;
    logic                  tcdm_gnt_i;
    logic                  tcdm_r_valid_i;
    logic [DATA_WIDTH-1:0] tcdm_r_rdata_i;
    logic                  data_valid_o;
    logic [DATA_WIDTH-1:0] data_o;
    logic                  data_ready_i;

    modport master (
        output tcdm_req_o, tcdm_addr_o, data_valid_o, data_o,
        input  tcdm_gnt_i, tcdm_r_valid_i, tcdm_r_rdata_i, data_ready_i
    );

    modport slave (
        input  tcdm_req_o, tcdm_addr_o, data_valid_o, data_o,
        output tcdm_gnt_i, tcdm_r_valid_i, tcdm_r_rdata_i, data_ready_i
    );
endinterface

// File: rtl/tcdm_burst_streamer.sv
// Strided TCDM burst reader: issues credit-limited requests and streams the
// in-order responses through a first-word-fall-through buffer.
module tcdm_burst_streamer #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned LEN_WIDTH  = 16,
    parameter int unsigned MAX_OUTST  = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic [ADDR_WIDTH-1:0] base_addr_i,
    input  logic [ADDR_WIDTH-1:0] stride_i,
    input  logic [LEN_WIDTH-1:0]  len_i,
    output logic                  busy_o,
    output logic                  done_o,
    tcdm_burst_streamer_if.master bus
);
    localparam int unsigned CNT_W = $clog2(MAX_OUTST + 1);
    localparam int unsigned PTR_W = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
    localparam int unsigned CRD_W = CNT_W + 1;

    typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_e;

    state_e                state_q, state_n;
    logic [LEN_WIDTH-1:0]  issued_q, issued_n, len_q, len_n;
    logic [ADDR_WIDTH-1:0] stride_q, stride_n, addr_q, addr_n;
    logic [CNT_W-1:0]      outst_q, outst_n, cnt_q, cnt_n;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_n, wr_ptr_q, wr_ptr_n;
    logic                  req_q, req_n, done_q, done_n, busy_q;
    logic                  valid_q, valid_n;
    logic [DATA_WIDTH-1:0] data_q, data_n;
    logic [DATA_WIDTH-1:0] mem_q [MAX_OUTST];
    logic                  gnt_acc, push, pop, head_from_push;
    logic [CRD_W-1:0]      credits_n;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(MAX_OUTST - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Next-state, counters, buffer pointers and next values of registered outputs
    always_comb begin
        state_n  = state_q;
        issued_n = issued_q;
        len_n    = len_q;
        stride_n = stride_q;
        addr_n   = addr_q;
        done_n   = 1'b0;

        gnt_acc = req_q & bus.tcdm_gnt_i;
        push    = bus.tcdm_r_valid_i & (outst_q != '0);
        pop     = valid_q & bus.data_ready_i;

        outst_n  = outst_q + CNT_W'(gnt_acc) - CNT_W'(push);
        cnt_n    = cnt_q + CNT_W'(push) - CNT_W'(pop);
        wr_ptr_n = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_n = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;

        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    if (len_i != '0) begin
                        state_n  = STREAM;
                        issued_n = '0;
                        len_n    = len_i;
                        stride_n = stride_i;
                        addr_n   = base_addr_i;
                        outst_n  = '0;
                    end else begin
                        done_n = 1'b1;
                    end
                end
            end
            STREAM: begin
                if (gnt_acc) begin
                    issued_n = issued_q + LEN_WIDTH'(1);
                    addr_n   = addr_q + stride_q;
                end
                if (issued_q == len_q) state_n = DRAIN;
            end
            DRAIN: begin
                if (outst_q == '0 && cnt_q == '0) begin
                    state_n = IDLE;
                    done_n  = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase

        credits_n = CRD_W'(outst_n) + CRD_W'(cnt_n);
        req_n     = (state_n == STREAM) && (issued_n < len_n) &&
                    (credits_n < CRD_W'(MAX_OUTST));

        // A word pushed into a buffer that is empty after this pop becomes the head
        head_from_push = push && (cnt_q == CNT_W'(pop));
        valid_n        = (cnt_n != '0);
        data_n         = head_from_push ? bus.tcdm_r_rdata_i : mem_q[rd_ptr_n];
        if (!valid_n) data_n = '0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            issued_q <= '0;
            len_q    <= '0;
            stride_q <= '0;
            addr_q   <= '0;
            outst_q  <= '0;
            cnt_q    <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            req_q    <= 1'b0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
            valid_q  <= 1'b0;
            data_q   <= '0;
        end else begin
            state_q  <= state_n;
            issued_q <= issued_n;
            len_q    <= len_n;
            stride_q <= stride_n;
            addr_q   <= addr_n;
            outst_q  <= outst_n;
            cnt_q    <= cnt_n;
            rd_ptr_q <= rd_ptr_n;
            wr_ptr_q <= wr_ptr_n;
            req_q    <= req_n;
            done_q   <= done_n;
            busy_q   <= (state_n != IDLE);
            valid_q  <= valid_n;
            data_q   <= data_n;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_ptr_q] <= bus.tcdm_r_rdata_i;
    end

    assign bus.tcdm_req_o   = req_q;
    assign bus.tcdm_addr_o  = addr_q;
    assign bus.data_valid_o = valid_q;
    assign bus.data_o       = data_q;
    assign busy_o           = busy_q;
    assign done_o           = done_q;

    // A response with nothing in flight is dropped by the datapath and flagged here
    a_no_orphan_rsp: assert property (@(posedge clk_i) disable iff (rst_i)
        !(bus.tcdm_r_valid_i && outst_q == '0));

endmodule

// File: tb/tb_tcdm_burst_streamer.sv
// Scoreboard bench for tcdm_burst_streamer: a randomized memory/consumer driver,
// a reference model of expected addresses and data, and a decoupled monitor.
module tb_tcdm_burst_streamer;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned LW = 16;
    localparam int unsigned MO = 4;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          start_i;
    logic [AW-1:0] base_addr_i, stride_i;
    logic [LW-1:0] len_i;
    logic          busy_o, done_o;

    tcdm_burst_streamer_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    tcdm_burst_streamer #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW), .MAX_OUTST(MO)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .start_i     (start_i),
        .base_addr_i (base_addr_i),
        .stride_i    (stride_i),
        .len_i       (len_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .bus         (bus)
    );

    always #5 clk_i = ~clk_i;

    int vec = 0;
    int errs = 0;

    logic [AW-1:0] exp_addr_q[$];
    logic [DW-1:0] exp_data_q[$];

    int gnt_mode = 0, ready_mode = 0, lat_mode = 0;
    bit manual = 1'b0;
    logic man_gnt = 1'b0, man_rv = 1'b0, man_ready = 1'b1;
    logic [DW-1:0] man_rd = '0;

    int dcyc = 0, mcyc = 0, last_due = 0;
    int pend_due[$];
    logic [DW-1:0] pend_data[$];

    int done_seen = 0, done_base = 0;
    int hs_cnt = 0, pop_cnt = 0, hs_first = -1, hs_last = -1;

    // Memory contents: a fixed scramble of the word address
    function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vec++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #2;
    endtask

    // Memory + consumer driver: the only writer of the slave side of the bus
    initial begin
        int due;
        bus.tcdm_gnt_i     = 1'b0;
        bus.tcdm_r_valid_i = 1'b0;
        bus.tcdm_r_rdata_i = '0;
        bus.data_ready_i   = 1'b0;
        forever begin
            @(posedge clk_i);
            #1;
            dcyc++;
            if (manual) begin
                bus.tcdm_gnt_i     = man_gnt;
                bus.tcdm_r_valid_i = man_rv;
                bus.tcdm_r_rdata_i = man_rd;
                bus.data_ready_i   = man_ready;
            end else begin
                bus.tcdm_r_valid_i = 1'b0;
                bus.tcdm_r_rdata_i = DW'($urandom);
                if (pend_due.size() != 0 && pend_due[0] <= dcyc) begin
                    bus.tcdm_r_valid_i = 1'b1;
                    bus.tcdm_r_rdata_i = pend_data.pop_front();
                    void'(pend_due.pop_front());
                end
                bus.tcdm_gnt_i = (gnt_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
                case (ready_mode)
                    0:       bus.data_ready_i = 1'b1;
                    1:       bus.data_ready_i = 1'b0;
                    default: bus.data_ready_i = ($urandom_range(0, 3) != 0);
                endcase
                if (bus.tcdm_req_o && bus.tcdm_gnt_i) begin
                    due = dcyc + 1 + ((lat_mode != 0) ? int'($urandom_range(0, 4)) : 0);
                    if (due <= last_due) due = last_due + 1;
                    last_due = due;
                    pend_due.push_back(due);
                    pend_data.push_back(mem_word(bus.tcdm_addr_o));
                end
            end
        end
    end

    // Monitor: compares grants, delivered words and completion against the model
    initial begin
        bit hold;
        logic [AW-1:0] hold_addr;
        logic [AW-1:0] ea;
        logic [DW-1:0] ed;
        hold = 1'b0;
        hold_addr = '0;
        forever begin
            @(posedge clk_i);
            #4;
            mcyc++;
            if (hold) begin
                check("req_held_until_gnt", bus.tcdm_req_o, 1);
                check("addr_held_until_gnt", bus.tcdm_addr_o, hold_addr);
            end
            hold = bus.tcdm_req_o && !bus.tcdm_gnt_i && !rst_i;
            hold_addr = bus.tcdm_addr_o;
            if (bus.tcdm_req_o && bus.tcdm_gnt_i && !rst_i) begin
                check("request_expected", exp_addr_q.size() != 0, 1);
                if (exp_addr_q.size() != 0) begin
                    ea = exp_addr_q.pop_front();
                    check("tcdm_addr", bus.tcdm_addr_o, ea);
                end
                hs_cnt++;
                if (hs_first < 0) hs_first = mcyc;
                hs_last = mcyc;
            end
            if (bus.data_valid_o && bus.data_ready_i && !rst_i) begin
                check("word_expected", exp_data_q.size() != 0, 1);
                if (exp_data_q.size() != 0) begin
                    ed = exp_data_q.pop_front();
                    check("data_o", bus.data_o, ed);
                end
                pop_cnt++;
            end
            if (hs_cnt - pop_cnt > int'(MO))
                check("credit_limit", hs_cnt - pop_cnt, MO);
            if (done_o) begin
                done_seen++;
                check("all_words_before_done", exp_data_q.size(), 0);
                check("idle_at_done", busy_o, 0);
            end
        end
    end

    task automatic launch(input logic [AW-1:0] base, input logic [AW-1:0] stride, input int len);
        logic [AW-1:0] a;
        hs_cnt = 0;
        pop_cnt = 0;
        hs_first = -1;
        hs_last = -1;
        done_base = done_seen;
        for (int i = 0; i < len; i++) begin
            a = base + stride * AW'(i);
            exp_addr_q.push_back(a);
            exp_data_q.push_back(mem_word(a));
        end
        start_i = 1'b1;
        base_addr_i = base;
        stride_i = stride;
        len_i = LW'(len);
        tick();
        start_i = 1'b0;
        base_addr_i = AW'($urandom);
        stride_i = AW'($urandom);
        len_i = LW'($urandom);
    endtask

    task automatic wait_done(input int len, input int budget);
        int n;
        n = 0;
        while (done_seen == done_base && n < budget) begin
            start_i = busy_o ? 1'($urandom_range(0, 1)) : 1'b0;
            tick();
            n++;
        end
        start_i = 1'b0;
        tick();
        check("done_pulses", done_seen - done_base, 1);
        check("words_delivered", pop_cnt, len);
        check("grants", hs_cnt, len);
        check("busy_after_done", busy_o, 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_req"}, bus.tcdm_req_o, 0);
        check({tag, "_addr"}, bus.tcdm_addr_o, 0);
        check({tag, "_valid"}, bus.data_valid_o, 0);
        check({tag, "_data"}, bus.data_o, 0);
        check({tag, "_busy"}, busy_o, 0);
        check({tag, "_done"}, done_o, 0);
    endtask

    initial begin
        int rl;
        rst_i = 1'b1;
        start_i = 1'b0;
        base_addr_i = '0;
        stride_i = '0;
        len_i = '0;
        repeat (3) tick();
        check_all_zero("reset");
        rst_i = 1'b0;
        tick();

        // Back-to-back burst at full rate
        gnt_mode = 0; lat_mode = 0; ready_mode = 0;
        tick();
        launch(32'h0000_1000, 32'd4, 8);
        wait_done(8, 200);
        check("consecutive_grants", hs_last - hs_first, 7);

        // Zero-length burst
        launch(32'h0000_5000, 32'd4, 0);
        check("len0_done", done_o, 1);
        check("len0_busy", busy_o, 0);
        check("len0_req", bus.tcdm_req_o, 0);
        tick();
        check("len0_done_single", done_o, 0);
        check("len0_done_count", done_seen - done_base, 1);

        // Address wrap
        launch(32'hFFFF_FFF8, 32'd4, 4);
        wait_done(4, 200);

        // Credit limit with a stalled consumer
        ready_mode = 1;
        tick();
        launch(32'h0000_4000, 32'd4, 10);
        repeat (20) tick();
        check("stall_grants", hs_cnt, MO);
        check("stall_req_low", bus.tcdm_req_o, 0);
        check("stall_valid", bus.data_valid_o, 1);
        check("stall_busy", busy_o, 1);
        ready_mode = 0;
        wait_done(10, 500);

        // Randomized handshakes, latencies and back-pressure
        for (int b = 0; b < 20; b++) begin
            gnt_mode = int'($urandom_range(0, 1));
            lat_mode = int'($urandom_range(0, 1));
            ready_mode = ($urandom_range(0, 1) == 0) ? 0 : 2;
            rl = int'($urandom_range(1, 24));
            launch(AW'($urandom), AW'($urandom_range(0, 64)), rl);
            wait_done(rl, 3000);
        end

        // Reset with two requests in flight, late responses, then a fresh burst
        ready_mode = 0;
        manual = 1'b1;
        man_gnt = 1'b0;
        man_rv = 1'b0;
        man_ready = 1'b1;
        tick();
        launch(32'h0000_2000, 32'd4, 8);
        check("rst_test_req", bus.tcdm_req_o, 1);
        man_gnt = 1'b1;
        tick();
        tick();
        man_gnt = 1'b0;
        tick();
        check("rst_test_inflight", hs_cnt, 2);
        rst_i = 1'b1;
        man_rv = 1'b1;
        man_rd = 32'hDEAD_BEEF;
        tick();
        check_all_zero("midrst");
        tick();
        check_all_zero("midrst_late_rsp");
        man_rv = 1'b0;
        tick();
        rst_i = 1'b0;
        exp_addr_q.delete();
        exp_data_q.delete();
        hs_cnt = 0;
        pop_cnt = 0;
        tick();
        check_all_zero("post_rst");
        manual = 1'b0;
        gnt_mode = 1; lat_mode = 1; ready_mode = 2;
        tick();
        launch(32'h0000_3000, 32'd8, 12);
        wait_done(12, 3000);

        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end
endmodule
